// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I fetch types and constants
package rv32i_pkg;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory request/response bus
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid buffer holding a fetched slot
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  fetch_slot_t din,
  output fetch_slot_t dout
);

  fetch_slot_t slot;

  // Flush and unload both empty the entry; the caller never loads during either.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot <= '{1'b0, 32'd0, NOP_INSTR};
    end else if (flush || unload) begin
      slot.valid <= 1'b0;
    end else if (load) begin
      slot <= din;
    end
  end

  assign dout = slot;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with IF/ID register and skid buffer
module if_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [31:0]     pc,
  input  logic            Stall,
  input  logic            Flush,
  if_fetch_unit_if.master imem,
  output logic            PCAdvance,
  output logic            if_id_valid,
  output logic [31:0]     if_id_pc,
  output logic [31:0]     if_id_instr
);

  fetch_state_t state, state_nxt;
  logic         req_nxt;
  logic [31:0]  addr_nxt;
  fetch_slot_t  if_id;
  fetch_slot_t  skid_q;
  fetch_slot_t  skid_din;
  logic         done, consume, accept;
  logic         skid_load, skid_unload;

  assign done        = imem.imem_req && imem.imem_ready;
  assign consume     = if_id.valid && !Stall;
  assign accept      = (state == REQ) && done && !Flush;
  assign PCAdvance   = Flush || accept;
  assign skid_unload = !Flush && consume && skid_q.valid;
  assign skid_load   = accept && if_id.valid && !consume;
  assign skid_din    = '{1'b1, imem.imem_addr, imem.imem_rdata};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= 32'd0;
    end else begin
      state          <= state_nxt;
      imem.imem_req  <= req_nxt;
      imem.imem_addr <= addr_nxt;
    end
  end

  // A full skid blocks new requests, so an accept never collides with an unload.
  always_comb begin
    state_nxt = state;
    req_nxt   = imem.imem_req;
    addr_nxt  = imem.imem_addr;
    case (state)
      IDLE: begin
        if (!Flush && !skid_q.valid) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = pc;
        end
      end
      REQ: begin
        if (done) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end else if (Flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (done) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      if_id <= '{1'b0, 32'd0, NOP_INSTR};
    end else if (Flush) begin
      if_id.valid <= 1'b0;
    end else if (skid_unload) begin
      if_id <= skid_q;
    end else if (accept && (!if_id.valid || consume)) begin
      if_id <= skid_din;
    end else if (consume) begin
      if_id.valid <= 1'b0;
    end
  end

  fetch_skid_buf u_skid (
    .Clk    (Clk),
    .Reset  (Reset),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (Flush),
    .din    (skid_din),
    .dout   (skid_q)
  );

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.valid ? if_id.instr : NOP_INSTR;

endmodule
